// File: rtl/ttt_board_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_board_ctrl
//
// Tic-tac-toe game state between the PS/2 mouse controller and the pixel
// generator. Left-button edges on a board cell place the current player's
// mark. Right-button edges start a new game. Wins and draws are detected
// one cycle after each placement.
//
// Parameters
//   X0, Y0  top-left corner of the board in pixels
//   CELL    cell side in pixels (board is 3*CELL square)
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   mouse_x/y    cursor position (10 bit), synchronous to clk
//   mouse_left   left button level
//   mouse_right  right button level (rising edge = new game)
//   board        packed board, cell i at [2i+1:2i], 00 empty / 01 X / 10 O
//   turn_x       1 = X to move, 0 = O to move
//   winner       00 none, 01 X, 10 O, 11 draw
//   game_over    high while the game is finished
//   place_pulse  one-cycle strobe when a mark is written
//   last_cell    index of the most recently placed cell, 4'hF = none
//
// state | meaning
// ------+------------------------------------------------------------
// PLAY  | waiting for a click on an empty cell (or a new-game request)
// CHECK | one cycle: evaluate lines for the mark just placed
// OVER  | game finished, only a new-game request is accepted
// ---------------------------------------------------------------------------
module ttt_board_ctrl #(
   parameter int X0   = 80,
   parameter int Y0   = 0,
   parameter int CELL = 160
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  mouse_x,
   input  logic [9:0]  mouse_y,
   input  logic        mouse_left,
   input  logic        mouse_right,
   output logic [17:0] board,
   output logic        turn_x,
   output logic [1:0]  winner,
   output logic        game_over,
   output logic        place_pulse,
   output logic [3:0]  last_cell
);

   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      CHECK = 2'd1,
      OVER  = 2'd2
   } state_t;

   // Boundaries extended to 11 bits so X0+3*CELL can never wrap.
   localparam logic [10:0] X_B0 = 11'(X0);
   localparam logic [10:0] X_B1 = 11'(X0 + CELL);
   localparam logic [10:0] X_B2 = 11'(X0 + 2 * CELL);
   localparam logic [10:0] X_B3 = 11'(X0 + 3 * CELL);
   localparam logic [10:0] Y_B0 = 11'(Y0);
   localparam logic [10:0] Y_B1 = 11'(Y0 + CELL);
   localparam logic [10:0] Y_B2 = 11'(Y0 + 2 * CELL);
   localparam logic [10:0] Y_B3 = 11'(Y0 + 3 * CELL);

   state_t      state_q;
   state_t      state_d;

   logic        left_q;
   logic        right_q;
   logic        left_rise;
   logic        right_rise;

   logic [17:0] board_q;
   logic        turn_x_q;
   logic [1:0]  winner_q;
   logic        place_pulse_q;
   logic [3:0]  last_cell_q;
   logic [3:0]  move_cnt_q;

   logic [10:0] x_ext;
   logic [10:0] y_ext;
   logic [1:0]  col;
   logic [1:0]  row;
   logic        in_board;
   logic [3:0]  cell_idx;
   logic        cell_empty;

   logic [1:0]  mark;
   logic [8:0]  mine;
   logic        line_win;
   logic        board_full;

   logic        do_clear;
   logic        do_place;
   logic        do_win;
   logic        do_draw;
   logic        do_toggle;

   // ---------------------------------------------------------------- edges
   assign left_rise  = mouse_left  & ~left_q;
   assign right_rise = mouse_right & ~right_q;

   // ---------------------------------------------------------- cell decode
   assign x_ext = {1'b0, mouse_x};
   assign y_ext = {1'b0, mouse_y};

   always_comb begin
      col = 2'd0;
      if (x_ext >= X_B2)
         col = 2'd2;
      else if (x_ext >= X_B1)
         col = 2'd1;

      row = 2'd0;
      if (y_ext >= Y_B2)
         row = 2'd2;
      else if (y_ext >= Y_B1)
         row = 2'd1;
   end

   assign in_board = (x_ext >= X_B0) && (x_ext < X_B3) &&
                     (y_ext >= Y_B0) && (y_ext < Y_B3);

   // row*3 + col, built from shifts and adds
   assign cell_idx = {2'b00, row} + {1'b0, row, 1'b0} + {2'b00, col};

   always_comb begin
      cell_empty = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (cell_idx == 4'(i))
            cell_empty = (board_q[2*i +: 2] == 2'b00);
      end
   end

   // ----------------------------------------------------------- line check
   // turn_x has not toggled yet while in CHECK, so it still names the mover.
   assign mark = turn_x_q ? 2'b01 : 2'b10;

   always_comb begin
      mine = '0;
      for (int i = 0; i < 9; i++)
         mine[i] = (board_q[2*i +: 2] == mark);
   end

   assign line_win = (mine[0] & mine[1] & mine[2]) |
                     (mine[3] & mine[4] & mine[5]) |
                     (mine[6] & mine[7] & mine[8]) |
                     (mine[0] & mine[3] & mine[6]) |
                     (mine[1] & mine[4] & mine[7]) |
                     (mine[2] & mine[5] & mine[8]) |
                     (mine[0] & mine[4] & mine[8]) |
                     (mine[2] & mine[4] & mine[6]);

   assign board_full = (move_cnt_q == 4'd9);

   // ------------------------------------------------------ state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= PLAY;
      else
         state_q <= state_d;
   end

   // ------------------------------------------------------ next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         PLAY: begin
            if (!right_rise && left_rise && in_board && cell_empty)
               state_d = CHECK;
         end
         CHECK: begin
            if (line_win || board_full)
               state_d = OVER;
            else
               state_d = PLAY;
         end
         OVER: begin
            if (right_rise)
               state_d = PLAY;
         end
         default: state_d = PLAY;
      endcase
   end

   // ------------------------------------------------------ FSM outputs
   always_comb begin
      do_clear  = 1'b0;
      do_place  = 1'b0;
      do_win    = 1'b0;
      do_draw   = 1'b0;
      do_toggle = 1'b0;
      game_over = 1'b0;
      case (state_q)
         PLAY: begin
            // A same-cycle right edge takes priority and drops the left edge.
            do_clear = right_rise;
            do_place = !right_rise && left_rise && in_board && cell_empty;
         end
         CHECK: begin
            do_win    = line_win;
            do_draw   = !line_win && board_full;
            do_toggle = !line_win && !board_full;
         end
         OVER: begin
            game_over = 1'b1;
            do_clear  = right_rise;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------ datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         left_q        <= 1'b0;
         right_q       <= 1'b0;
         board_q       <= '0;
         turn_x_q      <= 1'b1;
         winner_q      <= 2'b00;
         place_pulse_q <= 1'b0;
         last_cell_q   <= 4'hF;
         move_cnt_q    <= 4'd0;
      end else begin
         // Edge history tracks in every state so a held button never re-fires.
         left_q        <= mouse_left;
         right_q       <= mouse_right;
         place_pulse_q <= do_place;

         if (do_clear) begin
            board_q     <= '0;
            turn_x_q    <= 1'b1;
            winner_q    <= 2'b00;
            last_cell_q <= 4'hF;
            move_cnt_q  <= 4'd0;
         end

         if (do_place) begin
            for (int i = 0; i < 9; i++) begin
               if (cell_idx == 4'(i))
                  board_q[2*i +: 2] <= mark;
            end
            last_cell_q <= cell_idx;
            move_cnt_q  <= move_cnt_q + 4'd1;
         end

         if (do_win)
            winner_q <= mark;
         if (do_draw)
            winner_q <= 2'b11;
         if (do_toggle)
            turn_x_q <= ~turn_x_q;
      end
   end

   assign board       = board_q;
   assign turn_x      = turn_x_q;
   assign winner      = winner_q;
   assign place_pulse = place_pulse_q;
   assign last_cell   = last_cell_q;

endmodule

// File: tb/tb_ttt_board_ctrl.sv
module tb_ttt_board_ctrl;

   logic        clk;
   logic        rst;
   logic [9:0]  mouse_x;
   logic [9:0]  mouse_y;
   logic        mouse_left;
   logic        mouse_right;
   logic [17:0] board;
   logic        turn_x;
   logic [1:0]  winner;
   logic        game_over;
   logic        place_pulse;
   logic [3:0]  last_cell;

   int vectors;
   int miscompares;

   ttt_board_ctrl #(.X0(80), .Y0(0), .CELL(160)) dut (
      .clk         (clk),
      .rst         (rst),
      .mouse_x     (mouse_x),
      .mouse_y     (mouse_y),
      .mouse_left  (mouse_left),
      .mouse_right (mouse_right),
      .board       (board),
      .turn_x      (turn_x),
      .winner      (winner),
      .game_over   (game_over),
      .place_pulse (place_pulse),
      .last_cell   (last_cell)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   // Click at (x,y): left high for one cycle, then settle past CHECK.
   task automatic do_click(input logic [9:0] x, input logic [9:0] y, output int pulses);
      @(negedge clk);
      mouse_x    = x;
      mouse_y    = y;
      mouse_left = 1'b1;
      pulses     = 0;
      repeat (4) begin
         @(negedge clk);
         if (place_pulse) pulses++;
         mouse_left = 1'b0;
      end
   endtask

   // Click at the centre-ish of cell idx.
   task automatic click_cell(input int idx, output int pulses);
      logic [9:0] x;
      logic [9:0] y;
      x = 10'(100 + 160 * (idx % 3));
      y = 10'(10 + 160 * (idx / 3));
      do_click(x, y, pulses);
   endtask

   task automatic new_game;
      @(negedge clk);
      mouse_right = 1'b1;
      @(negedge clk);
      mouse_right = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      mouse_x = '0; mouse_y = '0; mouse_left = 1'b0; mouse_right = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({board, turn_x, winner, game_over, place_pulse, last_cell} !== {18'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'hF}) begin
         miscompares++;
         $display("FAIL reset_state: got board=%h turn_x=%b winner=%b over=%b pulse=%b last=%h expected 00000 1 00 0 0 f",
                  board, turn_x, winner, game_over, place_pulse, last_cell);
      end
   endtask

   task automatic test_first_move;
      @(negedge clk);
      mouse_x = 10'd100; mouse_y = 10'd10; mouse_left = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({board, last_cell, place_pulse, turn_x} !== {18'h00001, 4'd0, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL first_move_n1: got board=%h last=%h pulse=%b turn_x=%b expected 00001 0 1 1",
                  board, last_cell, place_pulse, turn_x);
      end
      @(negedge clk); mouse_left = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({board, place_pulse, turn_x, winner, game_over} !== {18'h00001, 1'b0, 1'b0, 2'b00, 1'b0}) begin
         miscompares++;
         $display("FAIL first_move_n2: got board=%h pulse=%b turn_x=%b winner=%b over=%b expected 00001 0 0 00 0",
                  board, place_pulse, turn_x, winner, game_over);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_x_win;
      int p;
      int total;
      new_game();
      total = 0;
      do_click(10'd100, 10'd10,  p); total += p;
      do_click(10'd250, 10'd10,  p); total += p;
      do_click(10'd250, 10'd250, p); total += p;
      do_click(10'd400, 10'd10,  p); total += p;
      do_click(10'd400, 10'd400, p); total += p;
      vectors++;
      if ({board, winner, game_over, turn_x, last_cell} !== {18'h10129, 2'b01, 1'b1, 1'b1, 4'd8}) begin
         miscompares++;
         $display("FAIL x_win: got board=%h winner=%b over=%b turn_x=%b last=%h expected 10129 01 1 1 8",
                  board, winner, game_over, turn_x, last_cell);
      end
      vectors++;
      if (total !== 5) begin
         miscompares++;
         $display("FAIL x_win_pulses: got %0d expected 5", total);
      end
      do_click(10'd100, 10'd400, p);
      vectors++;
      if ({board, winner, game_over, last_cell, 32'(p)} !== {18'h10129, 2'b01, 1'b1, 4'd8, 32'd0}) begin
         miscompares++;
         $display("FAIL click_in_over: got board=%h winner=%b over=%b last=%h pulses=%0d expected 10129 01 1 8 0",
                  board, winner, game_over, last_cell, p);
      end
   endtask

   task automatic test_ignored_clicks;
      int p;
      new_game();
      vectors++;
      if ({board, winner, game_over, turn_x, last_cell} !== {18'h0, 2'b00, 1'b0, 1'b1, 4'hF}) begin
         miscompares++;
         $display("FAIL clear_from_over: got board=%h winner=%b over=%b turn_x=%b last=%h expected 00000 00 0 1 f",
                  board, winner, game_over, turn_x, last_cell);
      end
      do_click(10'd50, 10'd100, p);
      vectors++;
      if ({board, turn_x, 32'(p)} !== {18'h0, 1'b1, 32'd0}) begin
         miscompares++;
         $display("FAIL outside_click: got board=%h turn_x=%b pulses=%0d expected 00000 1 0", board, turn_x, p);
      end
      do_click(10'd559, 10'd479, p);
      vectors++;
      if ({board, last_cell, 32'(p)} !== {18'h10000, 4'd8, 32'd1}) begin
         miscompares++;
         $display("FAIL corner_cell8: got board=%h last=%h pulses=%0d expected 10000 8 1", board, last_cell, p);
      end
      do_click(10'd560, 10'd100, p);
      vectors++;
      if ({board, 32'(p)} !== {18'h10000, 32'd0}) begin
         miscompares++;
         $display("FAIL right_edge_outside: got board=%h pulses=%0d expected 10000 0", board, p);
      end
      do_click(10'd80, 10'd0, p);
      vectors++;
      if ({board, turn_x, 32'(p)} !== {18'h10002, 1'b1, 32'd1}) begin
         miscompares++;
         $display("FAIL cell0_first: got board=%h turn_x=%b pulses=%0d expected 10002 1 1", board, turn_x, p);
      end
      do_click(10'd239, 10'd159, p);
      vectors++;
      if ({board, turn_x, last_cell, 32'(p)} !== {18'h10002, 1'b1, 4'd0, 32'd0}) begin
         miscompares++;
         $display("FAIL cell0_occupied: got board=%h turn_x=%b last=%h pulses=%0d expected 10002 1 0 0",
                  board, turn_x, last_cell, p);
      end
   endtask

   task automatic test_draw;
      int p;
      int order[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
      new_game();
      for (int k = 0; k < 8; k++) click_cell(order[k], p);
      vectors++;
      if ({board, winner, game_over, turn_x} !== {18'h06A59, 2'b00, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL draw_before_last: got board=%h winner=%b over=%b turn_x=%b expected 06a59 00 0 1",
                  board, winner, game_over, turn_x);
      end
      click_cell(order[8], p);
      vectors++;
      if ({board, winner, game_over, turn_x} !== {18'h16A59, 2'b11, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL draw_result: got board=%h winner=%b over=%b turn_x=%b expected 16a59 11 1 1",
                  board, winner, game_over, turn_x);
      end
      new_game();
      vectors++;
      if ({board, winner, game_over, turn_x, last_cell} !== {18'h0, 2'b00, 1'b0, 1'b1, 4'hF}) begin
         miscompares++;
         $display("FAIL draw_clear: got board=%h winner=%b over=%b turn_x=%b last=%h expected 00000 00 0 1 f",
                  board, winner, game_over, turn_x, last_cell);
      end
   endtask

   task automatic test_same_cycle_and_hold;
      int p;
      int pulses;
      click_cell(0, p);
      click_cell(1, p);
      @(negedge clk);
      mouse_x = 10'd250; mouse_y = 10'd250;
      mouse_left = 1'b1; mouse_right = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({board, place_pulse, turn_x, last_cell} !== {18'h0, 1'b0, 1'b1, 4'hF}) begin
         miscompares++;
         $display("FAIL same_cycle: got board=%h pulse=%b turn_x=%b last=%h expected 00000 0 1 f",
                  board, place_pulse, turn_x, last_cell);
      end
      @(negedge clk);
      mouse_left = 1'b0; mouse_right = 1'b0;
      @(negedge clk);
      mouse_left = 1'b1;
      pulses = 0;
      repeat (1000) begin
         @(negedge clk);
         if (place_pulse) pulses++;
      end
      mouse_left = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({board, turn_x, 32'(pulses)} !== {18'h00100, 1'b0, 32'd1}) begin
         miscompares++;
         $display("FAIL held_left: got board=%h turn_x=%b pulses=%0d expected 00100 0 1", board, turn_x, pulses);
      end
   endtask

   task automatic test_async_reset;
      new_game();
      @(negedge clk);
      mouse_x = 10'd100; mouse_y = 10'd10; mouse_left = 1'b1;
      @(posedge clk); #2;
      vectors++;
      if ({board, place_pulse} !== {18'h00001, 1'b1}) begin
         miscompares++;
         $display("FAIL pre_async_reset: got board=%h pulse=%b expected 00001 1", board, place_pulse);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if ({board, turn_x, winner, game_over, place_pulse, last_cell} !== {18'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'hF}) begin
         miscompares++;
         $display("FAIL async_reset: got board=%h turn_x=%b winner=%b over=%b pulse=%b last=%h expected 00000 1 00 0 0 f",
                  board, turn_x, winner, game_over, place_pulse, last_cell);
      end
      @(negedge clk);
      mouse_left = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({board, turn_x, game_over} !== {18'h0, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL after_async_reset: got board=%h turn_x=%b over=%b expected 00000 1 0", board, turn_x, game_over);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_first_move();
      test_x_win();
      test_ignored_clicks();
      test_draw();
      test_same_cycle_and_hold();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ttt_board_ctrl.md
# ttt_board_ctrl

Game-state stage between the PS/2 mouse controller and the pixel generator. Turns mouse button edges and cursor position into tic-tac-toe moves on a 3x3 board mapped onto the 640x480 screen. Tracks whose turn it is, detects wins and draws, and exports the packed board plus game status for rendering and for the 7-segment display.

## Interface
Parameters:
- X0, 80: left edge of board in pixels
- Y0, 0: top edge of board in pixels
- CELL, 160: cell side in pixels; board spans 3*CELL in each axis

Ports:
- clk  in  1  system clock (100 MHz, same domain as the mouse controller)
- rst  in  1  asynchronous, active-high reset
- mouse_x  in  10  cursor X, synchronous to clk
- mouse_y  in  10  cursor Y, synchronous to clk
- mouse_left  in  1  left button level
- mouse_right  in  1  right button level; a rising edge starts a new game
- board  out  18  cell i occupies bits [2i+1:2i]; 00 empty, 01 X, 10 O; i = row*3+col
- turn_x  out  1  1 = X to move, 0 = O to move
- winner  out  2  00 none, 01 X, 10 O, 11 draw
- game_over  out  1  high while in OVER
- place_pulse  out  1  one-cycle pulse when a mark is written
- last_cell  out  4  index of the last placed cell; 4'hF = none

## Operation
- Edge detect: left_q and right_q register the previous levels. left_rise = mouse_left & ~left_q. right_rise likewise.
- Cell decode is combinational with comparators only, no divider:
  - col = 0/1/2 for x in [X0, X0+CELL), [X0+CELL, X0+2*CELL), [X0+2*CELL, X0+3*CELL).
  - Rows decode the same way from Y0.
  - in_board is false outside these ranges.
- State machine PLAY, CHECK, OVER. Reset state is PLAY.
  - PLAY:
    - right_rise: clear board, move_cnt = 0, turn_x = 1, last_cell = F. Stay in PLAY.
    - left_rise (without right_rise) with in_board and the target cell empty: write 01 if turn_x, else 10. Set last_cell and pulse place_pulse. Increment move_cnt (4 bits). Go to CHECK.
    - left_rise outside the board or on an occupied cell: ignored.
  - CHECK (exactly one cycle): evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) for the mark just placed.
    - Line complete: winner = that mark, go to OVER.
    - Else move_cnt == 9: winner = 11, go to OVER.
    - Else toggle turn_x and return to PLAY.
    - Edges during CHECK are ignored. left_q and right_q still track, so a held button does not re-fire.
  - OVER:
    - left edges ignored.
    - right_rise: clear board, winner = 00, move_cnt = 0, turn_x = 1, last_cell = F. Go to PLAY.
- Same-cycle left_rise and right_rise: the right (clear) action wins and the left edge is dropped.
- A held button produces exactly one action.

## Timing
- Reset values: board 0, turn_x 1, winner 00, game_over 0, place_pulse 0, last_cell F, move_cnt 0, left_q 0, right_q 0, state PLAY.
- Reset is asynchronous: it takes effect immediately, including mid-CHECK or in OVER.
- left_rise sampled at edge N:
  - board, last_cell and place_pulse update at N+1. place_pulse is high for cycle N+1 only.
  - winner, game_over and turn_x update at N+2.
- right_rise sampled at edge N: cleared outputs are visible at N+1.
- board is stable except at a write or a clear. No partial updates.
- Move rate is at most one per 2 cycles. Real mouse events are far slower, so no queuing is needed.

## Test plan
- Reset, then left pulse at (100,10) → board = 18'h00001, last_cell = 0, place_pulse high 1 cycle, turn_x = 0 two cycles after the edge.
- Alternating clicks at (100,10), (250,10), (250,250), (400,10), (400,400) → cells 0 (X), 1 (O), 4 (X), 2 (O), 8 (X); winner = 01, game_over = 1, turn_x stays 1. A following left click at (100,400) leaves board unchanged.
- Click (50,100) → no change, no place_pulse. Click cell 0 twice → second click ignored, turn_x unchanged.
- Full draw sequence of cells 0, 1, 2, 4, 3, 5, 7, 6, 8 → winner = 11 after the 9th move. right_rise → board 0, winner 00, turn_x 1, game_over 0.
- left and right rising in the same cycle mid-game → board cleared, no mark placed. Holding left for 1000 cycles → exactly one placement.
- Assert rst asynchronously between clock edges during CHECK → all outputs reach reset values before the next clk edge.
